// File: rtl/shift_normalizer_if.sv
// Request/result bundle between a requester and the shift normalizer.
// Latency: none (pure wiring).
// Backpressure: none; the requester watches o_busy and i_start is dropped while busy.
interface shift_normalizer_if;
    logic        i_start;
    logic        i_mode;
    logic [31:0] i_data;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_data;
    logic [4:0]  o_shift_count;
    logic        o_zero;

    modport master (
        output i_start, i_mode, i_data,
        input  o_busy, o_valid, o_data, o_shift_count, o_zero
    );

    modport slave (
        input  i_start, i_mode, i_data,
        output o_busy, o_valid, o_data, o_shift_count, o_zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// Normalizes a 32-bit operand left (leading zeros) or right (trailing zeros) by binary search.
// Latency: start accepted at E0, o_valid high for one cycle after E5; next start may follow at E7.
// Backpressure: none; i_start is only sampled in IDLE, requests while busy are dropped.
module shift_normalizer (
    input  logic              i_clk,
    input  logic              i_rst_n,
    shift_normalizer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] work_q, work_d;
    logic        mode_q, mode_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_data_q, res_data_d;
    logic [4:0]  res_cnt_q, res_cnt_d;
    logic        res_zero_q, res_zero_d;

    // Current search step: width, zero test on the bits that would fall off, and shifted value.
    logic [5:0]  sh_w;
    logic        hit;
    logic [31:0] shifted;
    logic [31:0] step_work;
    logic [4:0]  step_cnt;

    // Shift width halves each step: 16, 8, 4, 2, 1.
    always_comb begin
        sh_w = 6'd1;
        case (step_q)
            3'd0:    sh_w = 6'd16;
            3'd1:    sh_w = 6'd8;
            3'd2:    sh_w = 6'd4;
            3'd3:    sh_w = 6'd2;
            default: sh_w = 6'd1;
        endcase
    end

    // Decide whether this step may shift: the w bits leaving the word must all be zero.
    always_comb begin
        hit       = 1'b0;
        shifted   = work_q;
        if (mode_q) begin
            hit     = ((work_q << (6'd32 - sh_w)) == 32'd0);
            shifted = work_q >> sh_w;
        end else begin
            hit     = ((work_q >> (6'd32 - sh_w)) == 32'd0);
            shifted = work_q << sh_w;
        end
        step_work = hit ? shifted : work_q;
        step_cnt  = hit ? (cnt_q + sh_w[4:0]) : cnt_q;
    end

    // Next-state logic for the IDLE -> RUN (5 steps) -> DONE -> IDLE sequence.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        work_d     = work_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        res_zero_d = res_zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    work_d  = bus.i_data;
                    mode_d  = bus.i_mode;
                    cnt_d   = 5'd0;
                    step_d  = 3'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d = step_work;
                cnt_d  = step_cnt;
                step_d = step_q + 3'd1;
                if (step_q == 3'd4) begin
                    state_d = S_DONE;
                    // Shifting never turns a nonzero word into zero, so an all-zero
                    // working word means the captured operand was zero.
                    if (work_q == 32'd0) begin
                        res_data_d = 32'd0;
                        res_cnt_d  = 5'd0;
                        res_zero_d = 1'b1;
                    end else begin
                        res_data_d = step_work;
                        res_cnt_d  = step_cnt;
                        res_zero_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            work_q     <= 32'd0;
            mode_q     <= 1'b0;
            cnt_q      <= 5'd0;
            res_data_q <= 32'd0;
            res_cnt_q  <= 5'd0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            work_q     <= work_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_valid       = (state_q == S_DONE);
    assign bus.o_data        = res_data_q;
    assign bus.o_shift_count = res_cnt_q;
    assign bus.o_zero        = res_zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed vector table, corner sequences, random ops.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_normalizer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_normalizer_if bus ();

    shift_normalizer u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        m;
        logic [31:0] d;
        logic [31:0] ed;
        logic [4:0]  ec;
        logic        ez;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: count leading/trailing zeros directly and shift by that amount.
    function automatic void model(input logic m, input logic [31:0] d,
                                  output logic [31:0] od, output logic [4:0] oc, output logic oz);
        int n;
        n = 0;
        if (d == 32'd0) begin
            od = 32'd0; oc = 5'd0; oz = 1'b1;
        end else begin
            if (!m) begin
                while (d[31 - n] == 1'b0) n++;
                od = d << n;
            end else begin
                while (d[n] == 1'b0) n++;
                od = d >> n;
            end
            oc = n[4:0];
            oz = 1'b0;
        end
    endfunction

    // Runs one operation from a negedge in IDLE; returns at the negedge after the return to IDLE.
    task automatic run_op(input string tag, input logic m, input logic [31:0] d,
                          input logic [31:0] ed, input logic [4:0] ec, input logic ez,
                          input bit poke);
        int lat;
        bit busy_ok;
        bus.i_start = 1'b1;
        bus.i_mode  = m;
        bus.i_data  = d;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_data  = $urandom();
        bus.i_mode  = ~m;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.o_valid && lat < 20) begin
            if (!bus.o_busy) busy_ok = 1'b0;
            bus.i_start = poke && (lat == 1);
            if (poke && lat == 1) begin
                bus.i_data = 32'h1;
                bus.i_mode = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        bus.i_start = 1'b0;
        valid_cyc = cyc;
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " busy_in_run"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_in_done"}, 32'(bus.o_busy), 32'd1);
        check({tag, " data"}, bus.o_data, ed);
        check({tag, " count"}, 32'(bus.o_shift_count), 32'(ec));
        check({tag, " zero"}, 32'(bus.o_zero), 32'(ez));
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(bus.o_valid), 32'd0);
        check({tag, " idle_not_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, " hold_data"}, bus.o_data, ed);
    endtask

    initial begin
        int t1;
        int pulses;
        logic        rm;
        logic [31:0] rd;
        logic [31:0] md;
        logic [4:0]  mc;
        logic        mz;

        vecs[0]  = '{1'b0, 32'h00010000, 32'h80000000, 5'd15, 1'b0};
        vecs[1]  = '{1'b1, 32'h00010000, 32'h00000001, 5'd16, 1'b0};
        vecs[2]  = '{1'b1, 32'h80000000, 32'h00000001, 5'd31, 1'b0};
        vecs[3]  = '{1'b0, 32'hC0000000, 32'hC0000000, 5'd0,  1'b0};
        vecs[4]  = '{1'b0, 32'h00000000, 32'h00000000, 5'd0,  1'b1};
        vecs[5]  = '{1'b1, 32'h00000000, 32'h00000000, 5'd0,  1'b1};
        vecs[6]  = '{1'b0, 32'h00000001, 32'h80000000, 5'd31, 1'b0};
        vecs[7]  = '{1'b0, 32'h12345678, 32'h91A2B3C0, 5'd3,  1'b0};
        vecs[8]  = '{1'b1, 32'h80000001, 32'h80000001, 5'd0,  1'b0};
        vecs[9]  = '{1'b1, 32'h12345678, 32'h02468ACF, 5'd3,  1'b0};
        vecs[10] = '{1'b0, 32'h0000FFFF, 32'hFFFF0000, 5'd16, 1'b0};

        bus.i_start = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_data  = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",  32'(bus.o_busy), 32'd0);
        check("reset valid", 32'(bus.o_valid), 32'd0);
        check("reset data",  bus.o_data, 32'd0);
        check("reset count", 32'(bus.o_shift_count), 32'd0);
        check("reset zero",  32'(bus.o_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, issued back to back: each start lands on the cycle after o_valid.
        t1 = 0;
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].ed, vecs[i].ec, vecs[i].ez, 1'b0);
            if (i > 0) check($sformatf("vec%0d period", i), 32'(valid_cyc - t1), 32'd7);
            t1 = valid_cyc;
        end

        // Outputs hold while idle.
        repeat (4) @(negedge clk);
        check("idle hold data",  bus.o_data, 32'hFFFF0000);
        check("idle hold count", 32'(bus.o_shift_count), 32'd16);
        check("idle hold valid", 32'(bus.o_valid), 32'd0);

        // Start pulsed at E2 must be dropped without queuing a second result.
        run_op("busy_poke", 1'b0, 32'h00010000, 32'h80000000, 5'd15, 1'b0, 1'b1);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        check("busy_poke no_extra_valid", 32'(pulses), 32'd0);

        // Reset during step 2 aborts with no result.
        bus.i_start = 1'b1;
        bus.i_mode  = 1'b0;
        bus.i_data  = 32'h00F00000;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy",  32'(bus.o_busy), 32'd0);
        check("midrst valid", 32'(bus.o_valid), 32'd0);
        check("midrst data",  bus.o_data, 32'd0);
        check("midrst count", 32'(bus.o_shift_count), 32'd0);
        check("midrst zero",  32'(bus.o_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        check("midrst no_valid", 32'(pulses), 32'd0);
        run_op("after_rst", 1'b1, 32'h00000600, 32'h00000003, 5'd9, 1'b0, 1'b0);

        // Random operands with a spread of leading/trailing zero counts.
        for (int i = 0; i < 60; i++) begin
            rm = 1'($urandom_range(0, 1));
            rd = $urandom();
            if (rm) rd = rd << $urandom_range(0, 31);
            else    rd = rd >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) rd = 32'd0;
            model(rm, rd, md, mc, mz);
            run_op($sformatf("rnd%0d m%0d d%08h", i, rm, rd), rm, rd, md, mc, mz, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
